// File: rtl/complemento_pipe_if.sv
// ============================================================================
//  complemento_pipe_if : operand/result handshake bundle for complemento_pipe
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface complemento_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             overflow;
  logic             zero;

  // Producer/consumer side (register file read port and ALU result mux)
  modport master (
    output in_valid, A, mode, out_ready,
    input  in_ready, out_valid, Y, overflow, zero
  );

  // Complement unit side
  modport slave (
    input  in_valid, A, mode, out_ready,
    output in_ready, out_valid, Y, overflow, zero
  );
endinterface

`default_nettype wire

// File: rtl/complemento_pipe.sv
// ============================================================================
//  complemento_pipe : two-stage pipelined one's/two's complement, abs, pass
//  Optional macro COMPLEMENTO_PIPE_SAT_EN saturates overflowing results.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module complemento_pipe #(
  parameter int WIDTH = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          enable,
  complemento_pipe_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef COMPLEMENTO_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] C_MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  localparam logic [1:0] C_MODE_ONES = 2'b00;
  localparam logic [1:0] C_MODE_TWOS = 2'b01;
  localparam logic [1:0] C_MODE_ABS  = 2'b10;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [1:0]       r_mode;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_overflow;
  logic             r_zero;

  logic             w_adv2;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_neg;
  logic             w_is_min;
  logic [WIDTH-1:0] w_y;
  logic             w_ovf;
  logic             w_zero;

  // Handshake: S2 frees up on consumption, S1 frees up when it advances
  assign w_adv2     = enable && r_s1_valid && (!r_out_valid || bus.out_ready);
  assign w_in_ready = enable && (!r_s1_valid || w_adv2);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && bus.out_ready;

  assign w_neg    = ~r_a + C_ONE;
  assign w_is_min = (r_a == C_MOST_NEG);

  always_comb begin
    w_y   = r_a;
    w_ovf = 1'b0;
    case (r_mode)
      C_MODE_ONES: w_y = ~r_a;
      C_MODE_TWOS: begin
        w_y   = w_neg;
        w_ovf = w_is_min;
      end
      C_MODE_ABS: begin
        if (r_a[WIDTH-1]) begin
          w_y   = w_neg;
          w_ovf = w_is_min;
        end
      end
      default: w_y = r_a;
    endcase
`ifdef COMPLEMENTO_PIPE_SAT_EN
    if (w_ovf) begin
      w_y = C_MOST_POS;
    end
`endif
  end

  assign w_zero = (w_y == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_a         <= '0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_a        <= bus.A;
        r_mode     <= bus.mode;
      end else if (w_adv2) begin
        r_s1_valid <= 1'b0;
      end

      // A concurrent consume and advance replaces S2 without a bubble
      if (w_adv2) begin
        r_out_valid <= 1'b1;
        r_y         <= w_y;
        r_overflow  <= w_ovf;
        r_zero      <= w_zero;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Y         = r_y;
  assign bus.overflow  = r_overflow;
  assign bus.zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_complemento_pipe.sv
// ============================================================================
//  tb_complemento_pipe : directed table and sequence checks for complemento_pipe
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_complemento_pipe;

  localparam int WIDTH = 8;

  logic clock;
  logic reset;
  logic enable;

  complemento_pipe_if #(.WIDTH(WIDTH)) bus ();

  complemento_pipe #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             z;
  } vec_t;

`ifdef COMPLEMENTO_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] C_OVF_Y = 8'h7F;
`else
  localparam logic [WIDTH-1:0] C_OVF_Y = 8'h80;
`endif

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   idx;
    int   got;
    logic seen;
    logic acc;
    logic xfer;

    vecs[0]  = '{2'b00, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 8'hFB, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{2'b01, 8'h80, C_OVF_Y, 1'b1, 1'b0};
    vecs[6]  = '{2'b10, 8'h80, C_OVF_Y, 1'b1, 1'b0};
    vecs[7]  = '{2'b11, 8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 8'h0F, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 8'h7F, 8'h81, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 8'h80, 8'h80, 1'b0, 1'b0};

    reset         = 1'b1;
    enable        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.Y, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_zero", bus.zero, 0);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Single operations: accept at edge k, result visible after edge k+1
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.A        = vecs[i].a;
      bus.mode     = vecs[i].mode;
      #1;
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_early", i), bus.out_valid, 0);
      tick();
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_y", i), bus.Y, vecs[i].y);
      chk($sformatf("v%0d_ovf", i), bus.overflow, vecs[i].ovf);
      chk($sformatf("v%0d_zero", i), bus.zero, vecs[i].z);
      tick();
      chk($sformatf("v%0d_drain", i), bus.out_valid, 0);
    end

    // Backpressure: stream 1..6 in pass mode, consumer stalled for 4 cycles
    idx  = 0;
    got  = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (idx < 6);
      bus.A         = 8'(idx + 1);
      bus.mode      = 2'b11;
      #1;
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (cyc == 3) begin
        chk("bp_full_in_ready", bus.in_ready, 0);
        chk("bp_accepts", idx, 2);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_y", bus.Y, 8'h01);
      end
      if (xfer) begin
        chk("bp_order", bus.Y, got + 1);
        got++;
        seen = 1'b1;
      end else if (seen) begin
        chk("bp_gap", bus.out_valid, 1);
      end
      tick();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chk("bp_count", got, 6);
    tick();

    // Enable drop with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.mode      = 2'b11;
    bus.A         = 8'h11;
    #1;
    chk("en_fill1", bus.in_ready, 1);
    tick();
    bus.A = 8'h12;
    #1;
    chk("en_fill2", bus.in_ready, 1);
    tick();
    bus.A         = 8'h13;
    enable        = 1'b0;
    bus.out_ready = 1'b1;
    for (int e = 0; e < 3; e++) begin
      #1;
      chk($sformatf("en_off%0d_in_ready", e), bus.in_ready, 0);
      if (e == 0) begin
        chk("en_drain_valid", bus.out_valid, 1);
        chk("en_drain_y", bus.Y, 8'h11);
      end else begin
        chk($sformatf("en_off%0d_valid", e), bus.out_valid, 0);
      end
      tick();
    end
    enable = 1'b1;
    #1;
    chk("en_on_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("en_next_valid", bus.out_valid, 1);
    chk("en_next_y", bus.Y, 8'h12);
    tick();
    chk("en_last_valid", bus.out_valid, 1);
    chk("en_last_y", bus.Y, 8'h13);
    tick();
    chk("en_empty", bus.out_valid, 0);

    // Reset mid-stream discards both stages
    bus.in_valid = 1'b1;
    bus.A        = 8'h21;
    tick();
    bus.A = 8'h22;
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_y", bus.Y, 0);
    chk("mrst_ovf", bus.overflow, 0);
    chk("mrst_zero", bus.zero, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mrst_stale%0d", k), bus.out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
